ysyx_24090003_wbu_stage: RTL and testbench
==========================================

Name: ysyx_24090003_wbu_stage

Overview:
- Parametrised, handshaked write-back stage. Successor to the combinational write-back unit.
- Captures one retiring instruction from the LSU into a single-entry holding register.
- Commits it to an internal integer register file and machine-mode CSR file when the downstream commit/trace port accepts it.
- On commit, produces PC redirects for ecall and mret.

Parameters:
- XLEN, 32, data/PC width.
- NREGS, 32, integer register count; 16 for RV32E. Address width AW = $clog2(NREGS).
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP = M).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept
- i_pc  in  XLEN  instruction PC
- i_rd_addr  in  AW  destination register
- i_reg_wen  in  1  register write enable
- i_wb_sel  in  2  write-back select: 00 ALU, 01 load data, 10 PC+4, 11 CSR old value
- i_alu_result  in  XLEN  ALU result
- i_mem_rdata  in  XLEN  load data, already extended
- i_csr_we  in  1  CSR access
- i_csr_addr  in  12  CSR address
- i_csr_op  in  2  01 RW, 10 RS, 11 RC, 00 none
- i_csr_wdata  in  XLEN  CSR source operand
- i_ecall  in  1  ecall
- i_mret  in  1  mret
- i_rs1_addr  in  AW  read port 1 address
- i_rs2_addr  in  AW  read port 2 address
- o_rs1_data  out  XLEN  read port 1 data
- o_rs2_data  out  XLEN  read port 2 data
- i_commit_ready  in  1  downstream accepts commit
- o_commit_valid  out  1  holding entry presented for commit
- o_commit_pc  out  XLEN  PC of held entry
- o_rd_wdata  out  XLEN  write-back value of held entry
- o_redirect  out  1  redirect in this cycle
- o_redirect_pc  out  XLEN  redirect target

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset values:
  - full = 0, so o_commit_valid = 0, o_redirect = 0, o_redirect_pc = 0.
  - All GPRs = 0.
  - mtvec = 0, mepc = 0, mcause = 0, mstatus = MSTATUS_RST.
  - o_ready = 1 in the first cycle after reset.
- State: two states, EMPTY (full = 0) and FULL (full = 1).
- Handshake and capture:
  - o_ready = !full | i_commit_ready.
  - Capture when i_valid & o_ready: all inputs are registered into the holding register and full <= 1.
- Commit:
  - Commit occurs when full & i_commit_ready.
  - If commit happens with no capture in the same cycle, full <= 0.
  - Simultaneous commit and capture: full stays 1 and the new entry replaces the old one. Back-to-back throughput is 1 instruction per cycle.
  - Latency: capture at edge N; earliest commit in cycle N+1; the GPR/CSR update is visible after edge N+2's preceding edge, i.e. at the commit-cycle edge.
- Outputs from the held entry:
  - o_commit_valid = full.
  - o_commit_pc = held PC.
  - o_rd_wdata is muxed from the held entry by wb_sel; 10 gives pc+4 with XLEN wrap-around.
  - For wb_sel 11, the value is the CSR's pre-commit value.
- GPR write: at commit, when reg_wen & rd != 0 & !ecall. x0 always reads 0.
- Read ports:
  - Combinational array read.
  - Bypass: if a commit writing rd is happening this cycle and rs == rd != 0, return o_rd_wdata.
- CSRs implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Unimplemented addresses read 0; writes to them are ignored.
  - CSR write at commit when csr_we & !ecall & !mret:
    - RW: new = wdata.
    - RS: new = old | wdata.
    - RC: new = old & ~wdata.
    - op 00: no write.
- ecall at commit:
  - mepc <= pc, mcause <= 11.
  - o_redirect = 1, o_redirect_pc = current mtvec.
  - No GPR or CSR-op write.
- mret at commit: o_redirect = 1, o_redirect_pc = mepc.
- Priority: ecall > mret > CSR op.
- o_redirect is combinational from the held entry, asserted only in the commit cycle; otherwise 0.
- Reset during FULL: the entry is dropped with no architectural update.
- Back-pressure: while i_commit_ready = 0 and full, the held entry and all outputs are stable and o_ready = 0.

Optional Feature:
- Macro: YSYX_24090003_WBU_COUNTERS_EN.
- When defined:
  - 64-bit mcycle (increments every cycle out of reset) and minstret (increments on each commit).
  - Readable at 0xB00/0xB80 (mcycle lo/hi) and 0xB02/0xB82 (minstret lo/hi).
  - CSR RW writes the addressed half. A write in a cycle takes priority over that cycle's increment.
  - Both counters reset to 0.
- When undefined: these addresses read 0, writes are ignored, and no counter logic is present.

Test Plan:
- Reset, then capture wb_sel 00, rd = 5, alu = 0x1234 with i_commit_ready = 1 -> next cycle o_commit_valid = 1; afterward rs1 = 5 reads 0x1234; rd = 0 write leaves x0 = 0.
- Hold i_commit_ready = 0 for 3 cycles with an entry held -> o_ready = 0, outputs stable; release -> commit in one cycle, o_ready = 1 in the same cycle.
- Back-to-back: 4 valid instructions every cycle writing x1..x4 = 1..4 with ready = 1 -> 4 commits on consecutive cycles; the rs1 = x3 bypass returns 3 in x3's commit cycle.
- CSRRW mtvec = 0x8000_0100 (rd = 6), then ecall at pc 0x8000_0040 -> x6 = 0 (old mtvec), redirect = 1, pc = 0x8000_0100, mepc = 0x8000_0040, mcause = 11; then mret -> redirect to 0x8000_0044 after CSRRW mepc = mepc + 4.
- CSRRS mstatus with 0x8, then CSRRC with 0x1800 -> reads return 0x1800, then 0x1808; final mstatus = 0x0008. Read of CSR 0x7C0 returns 0.
- With the counters macro: after N = 10 commits, CSRRS x7, minstret, x0 returns 10 (the counting instruction is excluded). Without the macro: returns 0.

Source files
------------

// File: rtl/ysyx_24090003_wbu_stage.sv
// Handshaked write-back stage: one-entry holding register, GPR file and M-mode CSRs, committed on downstream accept.
// Optional 64-bit mcycle/minstret counters are enabled by defining YSYX_24090003_WBU_COUNTERS_EN.
module ysyx_24090003_wbu_stage #(
    parameter int              XLEN        = 32,
    parameter int              NREGS       = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800),
    localparam int             AW          = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [AW-1:0]   i_rd_addr,
    input  logic            i_reg_wen,
    input  logic [1:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_csr_we,
    input  logic [11:0]     i_csr_addr,
    input  logic [1:0]      i_csr_op,
    input  logic [XLEN-1:0] i_csr_wdata,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_commit_ready,
    output logic            o_commit_valid,
    output logic [XLEN-1:0] o_commit_pc,
    output logic [XLEN-1:0] o_rd_wdata,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [AW-1:0]   rd;
        logic            reg_wen;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_rdata;
        logic            csr_we;
        logic [11:0]     csr_addr;
        logic [1:0]      csr_op;
        logic [XLEN-1:0] csr_wdata;
        logic            ecall;
        logic            mret;
    } entry_t;

    state_t          state_reg, state_next;
    entry_t          held_reg, entry_in;
    logic            full, commit, capture;
    logic            gpr_we, csr_wr;
    logic [XLEN-1:0] csr_old, csr_new;
    logic [XLEN-1:0] gpr_reg [NREGS];
    logic [XLEN-1:0] mstatus_reg, mtvec_reg, mepc_reg, mcause_reg;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_reg <= EMPTY;
        else          state_reg <= state_next;
    end

    // Next-state logic: a simultaneous commit and capture keeps the stage full
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (capture) state_next = FULL;
            FULL:    if (commit && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        full           = (state_reg == FULL);
        o_ready        = !full || i_commit_ready;
        o_commit_valid = full;
        commit         = full && i_commit_ready;
        capture        = i_valid && o_ready;
        o_redirect     = commit && (held_reg.ecall || held_reg.mret);
        o_redirect_pc  = '0;
        if (commit && held_reg.ecall)     o_redirect_pc = mtvec_reg;
        else if (commit && held_reg.mret) o_redirect_pc = mepc_reg;
    end

    assign entry_in = '{pc: i_pc, rd: i_rd_addr, reg_wen: i_reg_wen, wb_sel: i_wb_sel,
                        alu_result: i_alu_result, mem_rdata: i_mem_rdata, csr_we: i_csr_we,
                        csr_addr: i_csr_addr, csr_op: i_csr_op, csr_wdata: i_csr_wdata,
                        ecall: i_ecall, mret: i_mret};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)     held_reg <= '0;
        else if (capture) held_reg <= entry_in;
    end

`ifdef YSYX_24090003_WBU_COUNTERS_EN
    logic [63:0] mcycle_reg, minstret_reg;
`endif

    always_comb begin
        csr_old = '0;
        case (held_reg.csr_addr)
            CSR_MSTATUS:   csr_old = mstatus_reg;
            CSR_MTVEC:     csr_old = mtvec_reg;
            CSR_MEPC:      csr_old = mepc_reg;
            CSR_MCAUSE:    csr_old = mcause_reg;
`ifdef YSYX_24090003_WBU_COUNTERS_EN
            CSR_MCYCLE:    csr_old = XLEN'(mcycle_reg[31:0]);
            CSR_MCYCLEH:   csr_old = XLEN'(mcycle_reg[63:32]);
            CSR_MINSTRET:  csr_old = XLEN'(minstret_reg[31:0]);
            CSR_MINSTRETH: csr_old = XLEN'(minstret_reg[63:32]);
`endif
            default:       csr_old = '0;
        endcase
    end

    always_comb begin
        case (held_reg.csr_op)
            2'b01:   csr_new = held_reg.csr_wdata;
            2'b10:   csr_new = csr_old | held_reg.csr_wdata;
            2'b11:   csr_new = csr_old & ~held_reg.csr_wdata;
            default: csr_new = csr_old;
        endcase
        case (held_reg.wb_sel)
            2'b00:   o_rd_wdata = held_reg.alu_result;
            2'b01:   o_rd_wdata = held_reg.mem_rdata;
            2'b10:   o_rd_wdata = held_reg.pc + XLEN'(4);
            default: o_rd_wdata = csr_old;
        endcase
    end

    assign o_commit_pc = held_reg.pc;
    assign gpr_we = commit && held_reg.reg_wen && (held_reg.rd != '0) && !held_reg.ecall;
    assign csr_wr = commit && held_reg.csr_we && !held_reg.ecall && !held_reg.mret
                    && (held_reg.csr_op != 2'b00);

    // x0 is never written because gpr_we excludes rd == 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) gpr_reg[i] <= '0;
        end else if (gpr_we) begin
            gpr_reg[held_reg.rd] <= o_rd_wdata;
        end
    end

    logic [1:0][AW-1:0]   rs_addr;
    logic [1:0][XLEN-1:0] rs_data;
    assign rs_addr = {i_rs2_addr, i_rs1_addr};

    // Read ports see the value being committed this cycle
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        assign rs_data[gi] = (rs_addr[gi] == '0) ? '0 :
                             (gpr_we && rs_addr[gi] == held_reg.rd) ? o_rd_wdata :
                             gpr_reg[rs_addr[gi]];
    end
    assign o_rs1_data = rs_data[0];
    assign o_rs2_data = rs_data[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mstatus_reg <= MSTATUS_RST;
            mtvec_reg   <= '0;
            mepc_reg    <= '0;
            mcause_reg  <= '0;
        end else if (commit && held_reg.ecall) begin
            mepc_reg   <= held_reg.pc;
            mcause_reg <= XLEN'(11);
        end else if (csr_wr) begin
            case (held_reg.csr_addr)
                CSR_MSTATUS: mstatus_reg <= csr_new;
                CSR_MTVEC:   mtvec_reg   <= csr_new;
                CSR_MEPC:    mepc_reg    <= csr_new;
                CSR_MCAUSE:  mcause_reg  <= csr_new;
                default: ;
            endcase
        end
    end

`ifdef YSYX_24090003_WBU_COUNTERS_EN
    // An explicit write to a counter half overrides that cycle's increment
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= mcycle_reg + 64'd1;
            minstret_reg <= minstret_reg + 64'(commit);
            if (csr_wr) begin
                case (held_reg.csr_addr)
                    CSR_MCYCLE:    mcycle_reg   <= {mcycle_reg[63:32], csr_new[31:0]};
                    CSR_MCYCLEH:   mcycle_reg   <= {csr_new[31:0], mcycle_reg[31:0]};
                    CSR_MINSTRET:  minstret_reg <= {minstret_reg[63:32], csr_new[31:0]};
                    CSR_MINSTRETH: minstret_reg <= {csr_new[31:0], minstret_reg[31:0]};
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24090003_wbu_stage.sv
// Bench for ysyx_24090003_wbu_stage: directed scenarios then random traffic, all checked against a transaction-level model.
module tb_ysyx_24090003_wbu_stage;

    logic        clk = 1'b0;
    logic        i_rst_n, i_valid, o_ready, i_reg_wen, i_csr_we, i_ecall, i_mret;
    logic [31:0] i_pc, i_alu_result, i_mem_rdata, i_csr_wdata;
    logic [4:0]  i_rd_addr, i_rs1_addr, i_rs2_addr;
    logic [1:0]  i_wb_sel, i_csr_op;
    logic [11:0] i_csr_addr;
    logic [31:0] o_rs1_data, o_rs2_data, o_commit_pc, o_rd_wdata, o_redirect_pc;
    logic        i_commit_ready, o_commit_valid, o_redirect;

    always #5 clk = ~clk;

    ysyx_24090003_wbu_stage dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_rd_addr(i_rd_addr), .i_reg_wen(i_reg_wen), .i_wb_sel(i_wb_sel),
        .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata), .i_csr_we(i_csr_we),
        .i_csr_addr(i_csr_addr), .i_csr_op(i_csr_op), .i_csr_wdata(i_csr_wdata),
        .i_ecall(i_ecall), .i_mret(i_mret), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .i_commit_ready(i_commit_ready),
        .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc), .o_rd_wdata(o_rd_wdata),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic        v;
        logic [31:0] pc, alu, mem, cwd;
        logic [4:0]  rd;
        logic        wen, cwe, ec, mr;
        logic [1:0]  sel, op;
        logic [11:0] ca;
    } ent_t;

    ent_t        m_h;
    logic [31:0] m_gpr [32];
    logic [31:0] m_csrs [logic [11:0]];
`ifdef YSYX_24090003_WBU_COUNTERS_EN
    logic [63:0] m_mcycle, m_minstret;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_csr(input logic [11:0] a);
`ifdef YSYX_24090003_WBU_COUNTERS_EN
        if (a == 12'hB00) return m_mcycle[31:0];
        if (a == 12'hB80) return m_mcycle[63:32];
        if (a == 12'hB02) return m_minstret[31:0];
        if (a == 12'hB82) return m_minstret[63:32];
`endif
        if (m_csrs.exists(a)) return m_csrs[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_wdata();
        if (m_h.sel == 2'd0) return m_h.alu;
        if (m_h.sel == 2'd1) return m_h.mem;
        if (m_h.sel == 2'd2) return m_h.pc + 32'd4;
        return m_csr(m_h.ca);
    endfunction

    function automatic bit m_commit();
        return m_h.v && i_commit_ready;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_commit() && m_h.wen && !m_h.ec && m_h.rd == a) return m_wdata();
        return m_gpr[a];
    endfunction

    task automatic m_reset();
        m_h.v = 1'b0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_csrs.delete();
        m_csrs[12'h300] = 32'h0000_1800;
        m_csrs[12'h305] = 32'h0;
        m_csrs[12'h341] = 32'h0;
        m_csrs[12'h342] = 32'h0;
`ifdef YSYX_24090003_WBU_COUNTERS_EN
        m_mcycle = 64'h0;
        m_minstret = 64'h0;
`endif
    endtask

    task automatic m_step();
        logic [31:0] wd, old, nv;
        bit          cm, rdy;
        if (!i_rst_n) begin
            m_reset();
            return;
        end
        cm  = m_commit();
        rdy = !m_h.v || i_commit_ready;
        wd  = m_wdata();
        old = m_csr(m_h.ca);
        nv  = (m_h.op == 2'b01) ? m_h.cwd : (m_h.op == 2'b10) ? (old | m_h.cwd) : (old & ~m_h.cwd);
`ifdef YSYX_24090003_WBU_COUNTERS_EN
        m_mcycle   = m_mcycle + 64'd1;
        m_minstret = m_minstret + (cm ? 64'd1 : 64'd0);
`endif
        if (cm) begin
            if (m_h.ec) begin
                m_csrs[12'h341] = m_h.pc;
                m_csrs[12'h342] = 32'd11;
            end else begin
                if (m_h.wen && m_h.rd != 5'd0) m_gpr[m_h.rd] = wd;
                if (m_h.cwe && !m_h.mr && m_h.op != 2'b00) begin
                    if (m_csrs.exists(m_h.ca)) m_csrs[m_h.ca] = nv;
`ifdef YSYX_24090003_WBU_COUNTERS_EN
                    if (m_h.ca == 12'hB00) m_mcycle[31:0]    = nv;
                    if (m_h.ca == 12'hB80) m_mcycle[63:32]   = nv;
                    if (m_h.ca == 12'hB02) m_minstret[31:0]  = nv;
                    if (m_h.ca == 12'hB82) m_minstret[63:32] = nv;
`endif
                end
            end
        end
        if (i_valid && rdy) begin
            m_h = '{v: 1'b1, pc: i_pc, alu: i_alu_result, mem: i_mem_rdata, cwd: i_csr_wdata,
                    rd: i_rd_addr, wen: i_reg_wen, cwe: i_csr_we, ec: i_ecall, mr: i_mret,
                    sel: i_wb_sel, op: i_csr_op, ca: i_csr_addr};
        end else if (cm) begin
            m_h.v = 1'b0;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model with the DUT
    task automatic tick();
        bit redir;
        @(negedge clk);
        if (chk_en) begin
            redir = m_commit() && (m_h.ec || m_h.mr);
            check("ready", 32'(o_ready), 32'(!m_h.v || i_commit_ready));
            check("commit_valid", 32'(o_commit_valid), 32'(m_h.v));
            check("redirect", 32'(o_redirect), 32'(redir));
            check("rs1", o_rs1_data, m_rd(i_rs1_addr));
            check("rs2", o_rs2_data, m_rd(i_rs2_addr));
            if (m_h.v) begin
                check("commit_pc", o_commit_pc, m_h.pc);
                check("rd_wdata", o_rd_wdata, m_wdata());
            end
            if (redir) check("redirect_pc", o_redirect_pc, m_h.ec ? m_csr(12'h305) : m_csr(12'h341));
        end
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic cwe, input logic [11:0] ca,
                          input logic [1:0] op, input logic [31:0] cwd, input logic ec, input logic mr);
        i_valid = 1'b1; i_pc = pc; i_rd_addr = rd; i_reg_wen = 1'b1; i_wb_sel = sel;
        i_alu_result = alu; i_mem_rdata = $urandom; i_csr_we = cwe; i_csr_addr = ca;
        i_csr_op = op; i_csr_wdata = cwd; i_ecall = ec; i_mret = mr;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_ecall = 1'b0; i_mret = 1'b0;
    endtask

    // Capture one instruction; on return it is held and visible on the outputs
    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic cwe, input logic [11:0] ca,
                         input logic [1:0] op, input logic [31:0] cwd, input logic ec, input logic mr);
        set_in(pc, rd, sel, alu, cwe, ca, op, cwd, ec, mr);
        tick();
        idle();
    endtask

    logic [11:0] csr_tab [10];
    logic [31:0] hold_pc;

    initial begin
        csr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0,
                    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h000};
        i_rst_n = 1'b0; i_commit_ready = 1'b0; i_rs1_addr = 5'd0; i_rs2_addr = 5'd0;
        set_in(32'h0, 5'd0, 2'd0, 32'h0, 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
        idle();
        m_reset();
        tick();
        tick();
        check("rst_commit_valid", 32'(o_commit_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_redirect", 32'(o_redirect), 32'd0);
        check("rst_redirect_pc", o_redirect_pc, 32'h0);
        i_rst_n = 1'b1; i_commit_ready = 1'b1; chk_en = 1'b1;

        // Basic ALU write-back and x0 protection
        issue(32'h100, 5'd5, 2'd0, 32'h1234, 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("t1_valid", 32'(o_commit_valid), 32'd1);
        tick();
        i_rs1_addr = 5'd5;
        tick();
        check("t1_x5", o_rs1_data, 32'h1234);
        issue(32'h104, 5'd0, 2'd0, 32'hDEAD, 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
        tick();
        i_rs1_addr = 5'd0;
        tick();
        check("t1_x0", o_rs1_data, 32'h0);

        // Back-pressure holds the entry and outputs stable
        i_commit_ready = 1'b0;
        issue(32'h200, 5'd8, 2'd2, 32'h55, 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_pc", o_commit_pc, 32'h200);
            check("bp_wdata", o_rd_wdata, 32'h204);
            tick();
        end
        i_commit_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(o_ready), 32'd1);
        tick();
        check("bp_drained", 32'(o_commit_valid), 32'd0);

        // Back-to-back x1..x4, bypass on x3
        i_rs1_addr = 5'd3;
        for (int k = 1; k <= 4; k++) begin
            set_in(32'h300 + 32'(4 * k), 5'(k), 2'd0, 32'(k), 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
            tick();
            if (k == 3) check("b2b_bypass_x3", o_rs1_data, 32'd3);
        end
        idle();
        tick();

        // CSRRW mtvec, ecall, mepc/mcause readback, mret
        issue(32'h400, 5'd6, 2'd3, 32'h0, 1'b1, 12'h305, 2'b01, 32'h8000_0100, 1'b0, 1'b0);
        check("csrrw_old_mtvec", o_rd_wdata, 32'h0);
        tick();
        issue(32'h8000_0040, 5'd7, 2'd0, 32'h9, 1'b1, 12'h305, 2'b01, 32'h0, 1'b1, 1'b0);
        check("ecall_redirect", 32'(o_redirect), 32'd1);
        check("ecall_target", o_redirect_pc, 32'h8000_0100);
        tick();
        i_rs1_addr = 5'd6; i_rs2_addr = 5'd7;
        issue(32'h404, 5'd9, 2'd3, 32'h0, 1'b1, 12'h341, 2'b10, 32'h0, 1'b0, 1'b0);
        check("x6_old_mtvec", o_rs1_data, 32'h0);
        check("mepc_read", o_rd_wdata, 32'h8000_0040);
        tick();
        issue(32'h408, 5'd9, 2'd3, 32'h0, 1'b1, 12'h342, 2'b10, 32'h0, 1'b0, 1'b0);
        check("mcause_read", o_rd_wdata, 32'd11);
        tick();
        issue(32'h40C, 5'd0, 2'd3, 32'h0, 1'b1, 12'h341, 2'b01, 32'h8000_0044, 1'b0, 1'b0);
        tick();
        issue(32'h410, 5'd0, 2'd0, 32'h0, 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b1);
        check("mret_redirect", 32'(o_redirect), 32'd1);
        check("mret_target", o_redirect_pc, 32'h8000_0044);
        tick();

        // mstatus set/clear and an unimplemented CSR
        issue(32'h500, 5'd10, 2'd3, 32'h0, 1'b1, 12'h300, 2'b10, 32'h8, 1'b0, 1'b0);
        check("mstatus_rs_old", o_rd_wdata, 32'h1800);
        tick();
        issue(32'h504, 5'd10, 2'd3, 32'h0, 1'b1, 12'h300, 2'b11, 32'h1800, 1'b0, 1'b0);
        check("mstatus_rc_old", o_rd_wdata, 32'h1808);
        tick();
        issue(32'h508, 5'd10, 2'd3, 32'h0, 1'b1, 12'h300, 2'b10, 32'h0, 1'b0, 1'b0);
        check("mstatus_final", o_rd_wdata, 32'h0008);
        tick();
        issue(32'h50C, 5'd11, 2'd3, 32'h0, 1'b1, 12'h7C0, 2'b01, 32'hFFFF, 1'b0, 1'b0);
        tick();
        issue(32'h510, 5'd11, 2'd3, 32'h0, 1'b1, 12'h7C0, 2'b10, 32'h0, 1'b0, 1'b0);
        check("csr_7c0", o_rd_wdata, 32'h0);
        tick();

        // minstret after ten commits
        issue(32'h600, 5'd0, 2'd3, 32'h0, 1'b1, 12'hB02, 2'b01, 32'h0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            issue(32'h604 + 32'(4 * k), 5'd12, 2'd0, 32'(k), 1'b0, 12'h0, 2'd0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        issue(32'h640, 5'd7, 2'd3, 32'h0, 1'b1, 12'hB02, 2'b10, 32'h0, 1'b0, 1'b0);
`ifdef YSYX_24090003_WBU_COUNTERS_EN
        check("minstret_10", o_rd_wdata, 32'd10);
`else
        check("minstret_absent", o_rd_wdata, 32'd0);
`endif
        tick();

        // Reset while full drops the entry
        i_commit_ready = 1'b0;
        issue(32'h700, 5'd13, 2'd0, 32'h77, 1'b0, 12'h0, 2'd0, 32'h0, 1'b1, 1'b0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1; i_commit_ready = 1'b1;
        #1;
        check("rstfull_valid", 32'(o_commit_valid), 32'd0);
        check("rstfull_redirect", 32'(o_redirect), 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            hold_pc = $urandom;
            set_in(hold_pc, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 1)), csr_tab[$urandom_range(0, 9)],
                   2'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
            i_valid        = ($urandom_range(0, 3) != 0);
            i_reg_wen      = ($urandom_range(0, 3) != 0);
            i_commit_ready = ($urandom_range(0, 3) != 0);
            i_rs1_addr     = 5'($urandom_range(0, 31));
            i_rs2_addr     = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        i_commit_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
